// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared scheduler state encoding and width helper for the async FIFO blocks
package async_fifo_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/async_fifo_rr_pick.sv
// async_fifo_rr_pick: combinational round-robin picker searching rr_ptr+1, rr_ptr+2, ... modulo N
module async_fifo_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] k;
  always_comb begin
    k = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(rr_ptr) + i) % N);
      if (req[k]) idx = k;
    end
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/async_fifo_rd_arbiter.sv
// async_fifo_rd_arbiter: round-robin burst/packet scheduler draining NUM_CH FWFT FIFOs into one stream
module async_fifo_rd_arbiter
  import async_fifo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8,
  parameter bit PKT_MODE   = 1'b1,
  localparam int CW = clog2(NUM_CH),
  localparam int BW = clog2(MAX_BURST + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [NUM_CH-1:0]            ch_enable_i,
  input  logic [NUM_CH-1:0]            fifo_rempty_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rdata_i,
  output logic [NUM_CH-1:0]            fifo_rd_en_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [CW-1:0]                out_ch_o,
  output logic                         busy_o,
  output logic [NUM_CH-1:0]            grant_o
);
  state_t state, state_d;
  logic [CW-1:0] g, rr_ptr, pick_idx;
  logic [NUM_CH-1:0] req, pick_grant;
  logic [BW-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0] g_data;
  logic pick_any, out_free, g_empty, pop, last, cnt_hit, rel;

  assign req      = ~fifo_rempty_i & ch_enable_i;
  assign busy_o   = state == ST_BURST;
  assign g_empty  = fifo_rempty_i[g];
  assign g_data   = fifo_rdata_i[int'(g)*DATA_WIDTH +: DATA_WIDTH];
  assign out_free = !out_valid_o || out_ready_i;
  assign pop      = busy_o && !g_empty && out_free;
  assign fifo_rd_en_o = pop ? grant_o : '0;
  assign last     = PKT_MODE && g_data[DATA_WIDTH-1];
  assign cnt_hit  = !PKT_MODE && beat_cnt == BW'(MAX_BURST - 1);
  assign rel      = busy_o && ((pop && (last || cnt_hit)) ||
                    (!PKT_MODE && out_free && (g_empty || !ch_enable_i[g])));

  async_fifo_rr_pick #(.N(NUM_CH), .IW(CW)) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb state_d = busy_o ? (rel ? ST_IDLE : ST_BURST) : (pick_any ? ST_BURST : ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state <= ST_IDLE;
    else state <= state_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      g           <= '0;
      rr_ptr      <= CW'(NUM_CH - 1);
      beat_cnt    <= '0;
      grant_o     <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else begin
      if (!busy_o && pick_any) begin
        g        <= pick_idx;
        grant_o  <= pick_grant;
        beat_cnt <= '0;
      end
      if (pop && beat_cnt != BW'(MAX_BURST)) beat_cnt <= beat_cnt + BW'(1);
      if (rel) begin
        grant_o <= '0;
        rr_ptr  <= g;
      end
      if (pop) begin
        out_data_o  <= g_data;
        out_ch_o    <= g;
        out_valid_o <= 1'b1;
      end else if (out_ready_i) out_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_async_fifo_rd_arbiter.sv
// tb_async_fifo_rd_arbiter: scoreboard bench driving a packet-mode and a burst-mode scheduler from FIFO models
module tb_async_fifo_rd_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MB0 = 8;
  localparam int MB1 = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] en [2], rempty [2], rd_en [2], grant [2];
  logic [N*DW-1:0] rdata [2];
  logic valid [2], ready [2], busy [2];
  logic [DW-1:0] odata [2];
  logic [1:0] och [2];

  logic [DW-1:0] fq [2][N][$];
  logic [DW-1:0] sb [2][N][$];
  int exp_ch [2][$];
  int exp_len [2][$];
  int total = 0;
  int bad = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    async_fifo_rd_arbiter #(
      .NUM_CH(N), .DATA_WIDTH(DW), .MAX_BURST(d == 0 ? MB0 : MB1), .PKT_MODE(d == 0)
    ) u_dut (
      .clk_i(clk), .reset_n_i(reset_n), .ch_enable_i(en[d]), .fifo_rempty_i(rempty[d]),
      .fifo_rdata_i(rdata[d]), .fifo_rd_en_o(rd_en[d]), .out_valid_o(valid[d]),
      .out_ready_i(ready[d]), .out_data_o(odata[d]), .out_ch_o(och[d]), .busy_o(busy[d]),
      .grant_o(grant[d])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input int ptr, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(ptr + i) % N]) return N'(1) << ((ptr + i) % N);
    return '0;
  endfunction

  task automatic sync_fifo();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        rempty[d][c] = fq[d][c].size() == 0;
        rdata[d][c*DW +: DW] = fq[d][c].size() != 0 ? fq[d][c][0] : '0;
      end
  endtask

  task automatic push(input int d, input int c, input logic [DW-1:0] v);
    fq[d][c].push_back(v);
    sb[d][c].push_back(v);
  endtask

  task automatic tick();
    logic [N-1:0] lp [2];
    sync_fifo();
    @(negedge clk);
    lp[0] = rd_en[0];
    lp[1] = rd_en[1];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++)
        if (lp[d][c] && fq[d][c].size() != 0) void'(fq[d][c].pop_front());
    sync_fifo();
  endtask

  function automatic bit drained();
    for (int d = 0; d < 2; d++) begin
      if (valid[d]) return 1'b0;
      for (int c = 0; c < N; c++) if (sb[d][c].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  logic [N-1:0] p_grant [2], p_req [2];
  logic p_ok [2], p_hold [2], pkt_open [2], last_pop [2];
  logic [DW-1:0] p_data [2];
  logic [1:0] p_ch [2];
  int rr [2], blen [2], pkt_ch [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      string t;
      t = $sformatf("d%0d ", d);
      if (!reset_n) begin
        rr[d] = N - 1;
        p_ok[d] = 1'b0;
        p_hold[d] = 1'b0;
        pkt_open[d] = 1'b0;
        last_pop[d] = 1'b0;
        blen[d] = 0;
        p_grant[d] = '0;
      end else begin
        chk({t, "rd_en_onehot0"}, 32'($onehot0(rd_en[d])), 1);
        chk({t, "rd_en_on_empty"}, rd_en[d] & rempty[d], 0);
        chk({t, "rd_en_pop_rule"}, rd_en[d],
            (busy[d] && (grant[d] & ~rempty[d]) != '0 && (!valid[d] || ready[d])) ? grant[d] : '0);
        chk({t, "grant_vs_busy"}, |grant[d], busy[d]);
        if (p_ok[d]) begin
          if (p_grant[d] == '0) chk({t, "rr_pick"}, grant[d], rr_pick(rr[d], p_req[d]));
          else if (grant[d] == '0) begin
            for (int c = 0; c < N; c++) if (p_grant[d][c]) rr[d] = c;
            if (d == 0) chk({t, "release_on_last"}, last_pop[d], 1);
            else chk({t, "burst_le_max"}, blen[d] <= MB1, 1);
            if (exp_len[d].size() != 0) chk({t, "burst_len"}, blen[d], exp_len[d].pop_front());
            blen[d] = 0;
          end else chk({t, "grant_stable"}, grant[d], p_grant[d]);
          if (p_hold[d]) begin
            chk({t, "hold_valid"}, valid[d], 1);
            chk({t, "hold_data"}, odata[d], p_data[d]);
            chk({t, "hold_ch"}, och[d], p_ch[d]);
          end
        end
        for (int c = 0; c < N; c++)
          if (rd_en[d][c]) begin
            blen[d]++;
            last_pop[d] = rdata[d][c*DW + DW - 1];
          end
        if (valid[d] && ready[d]) begin
          chk({t, "beat_expected"}, sb[d][och[d]].size() != 0, 1);
          if (sb[d][och[d]].size() != 0) chk({t, "beat_data"}, odata[d], sb[d][och[d]].pop_front());
          if (exp_ch[d].size() != 0) chk({t, "beat_order"}, och[d], exp_ch[d].pop_front());
          if (d == 0) begin
            if (pkt_open[d]) chk({t, "pkt_interleave"}, och[d], pkt_ch[d]);
            pkt_open[d] = !odata[d][DW-1];
            pkt_ch[d] = och[d];
          end
        end
        p_ok[d] = 1'b1;
        p_grant[d] = grant[d];
        p_req[d] = ~rempty[d] & en[d];
        p_hold[d] = valid[d] && !ready[d];
        p_data[d] = odata[d];
        p_ch[d] = och[d];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [DW-1:0] snap;
  int rem [N];

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = '1;
      ready[d] = 1'b1;
    end
    for (int c = 0; c < N; c++) rem[c] = 0;
    sync_fifo();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset valid", valid[d], 0);
      chk("reset data", odata[d], 0);
      chk("reset ch", och[d], 0);
      chk("reset rd_en", rd_en[d], 0);
      chk("reset grant", grant[d], 0);
      chk("reset busy", busy[d], 0);
    end
    reset_n = 1'b1;
    tick();

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) begin
        push(0, c, DW'(16'h0100 + 16 * c + 2 * r));
        push(0, c, DW'(16'h8101 + 16 * c + 2 * r));
        exp_ch[0].push_back(c);
        exp_ch[0].push_back(c);
      end
    for (int i = 0; i < 10; i++) begin
      push(1, 0, DW'(16'h0300 + i));
      exp_ch[1].push_back(0);
    end
    push(1, 1, 16'h0400);
    exp_ch[1] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    exp_len[1] = '{4, 1, 4, 2};
    repeat (32) tick();

    push(0, 2, 16'h0001);
    push(0, 2, 16'h0002);
    push(0, 2, 16'h8003);
    tick();
    chk("single grant", grant[0], 4'b0100);
    chk("single no beat yet", valid[0], 0);
    tick();
    chk("single beat1", odata[0], 16'h0001);
    chk("single ch", och[0], 2);
    tick();
    chk("single beat2", odata[0], 16'h0002);
    tick();
    chk("single beat3", odata[0], 16'h8003);
    chk("single released", busy[0], 0);
    tick();
    chk("single valid drop", valid[0], 0);
    push(0, 2, 16'h8004);
    push(0, 3, 16'h8005);
    exp_ch[0] = '{3, 2};
    tick();
    chk("rr after ch2", grant[0], 4'b1000);
    repeat (8) tick();

    for (int i = 0; i < 5; i++) push(0, 1, DW'(16'h0010 + i));
    push(0, 1, 16'h8015);
    repeat (2) tick();
    ready[0] = 1'b0;
    snap = odata[0];
    chk("bp valid", valid[0], 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp data stable", odata[0], snap);
      chk("bp no pop", rd_en[0], 0);
    end
    ready[0] = 1'b1;
    repeat (10) tick();

    push(0, 1, 16'h0021);
    push(0, 1, 16'h0022);
    exp_ch[0] = '{1, 1, 1, 3};
    repeat (4) tick();
    push(0, 3, 16'h8031);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("starve grant held", grant[0], 4'b0010);
      chk("starve no pop", rd_en[0], 0);
    end
    push(0, 1, 16'h8023);
    repeat (8) tick();

    for (int i = 0; i < 5; i++) push(0, 2, DW'(16'h0040 + i));
    push(0, 2, 16'h8045);
    repeat (2) tick();
    ready[0] = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst valid", valid[0], 0);
    chk("arst data", odata[0], 0);
    chk("arst grant", grant[0], 0);
    chk("arst busy", busy[0], 0);
    chk("arst rd_en", rd_en[0], 0);
    for (int d = 0; d < 2; d++) begin
      ready[d] = 1'b1;
      exp_ch[d].delete();
      exp_len[d].delete();
      for (int c = 0; c < N; c++) begin
        fq[d][c].delete();
        sb[d][c].delete();
      end
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    push(0, 1, 16'h8051);
    push(0, 3, 16'h8053);
    push(0, 0, 16'h8050);
    exp_ch[0] = '{0, 1, 3};
    tick();
    chk("restart at ch0", grant[0], 4'b0001);
    repeat (10) tick();

    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        ready[d] = $urandom_range(0, 3) != 0;
        for (int c = 0; c < N; c++) begin
          en[d][c] = $urandom_range(0, 7) != 0;
          if ($urandom_range(0, 3) == 0 && fq[d][c].size() < 16) begin
            if (d == 0) begin
              if (rem[c] == 0) rem[c] = $urandom_range(1, 12);
              push(0, c, {rem[c] == 1, 15'($urandom)});
              rem[c]--;
            end else push(1, c, DW'($urandom));
          end
        end
      end
      tick();
    end

    for (int c = 0; c < N; c++)
      if (rem[c] != 0) begin
        push(0, c, {1'b1, 15'($urandom)});
        rem[c] = 0;
      end
    for (int d = 0; d < 2; d++) begin
      en[d] = '1;
      ready[d] = 1'b1;
    end
    for (int k = 0; k < 2000 && !drained(); k++) tick();
    chk("drain complete", drained(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
